// File: rtl/arbitro_de_funcionalidade_seq_pkg.sv
// Shared definitions for the sequential function arbiter: controller states,
// special user codes and the permission/priority table.
package pkg_funcionalidade;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARBITRATE = 2'd1,
    HOLD      = 2'd2,
    PILOTO    = 2'd3
  } estado_t;

  localparam logic [2:0] USER_ADMIN  = 3'b101;
  localparam logic [2:0] USER_PILOTO = 3'b111;

  localparam logic [1:0] PRIO_ADMIN = 2'd3;
  localparam logic [1:0] PRIO_USER  = 2'd1;
  localparam logic [1:0] PRIO_NONE  = 2'd0;

  localparam int unsigned FUNC_MAX_ADMIN = 7;
  localparam int unsigned FUNC_MAX_USER  = 3;

  // Codes are taken zero-extended so any USER_W/FUNC_W can call these.
  function automatic logic [1:0] prioridade(input logic [31:0] user);
    if (user == 32'(USER_ADMIN))
      return PRIO_ADMIN;
    if (user == 32'd1 || user == 32'd3 || user == 32'd6)
      return PRIO_USER;
    return PRIO_NONE;
  endfunction

  function automatic logic permitido(input logic [31:0] user, input logic [31:0] func);
    logic [1:0] p;
    p = prioridade(user);
    if (func == 32'd0)
      return 1'b0;
    if (p == PRIO_ADMIN)
      return func <= FUNC_MAX_ADMIN;
    if (p == PRIO_USER)
      return func <= FUNC_MAX_USER;
    return 1'b0;
  endfunction

endpackage

// File: rtl/arbitro_de_funcionalidade_seq_arbitro_por_funcao.sv
// Winner selection for one function code: highest-priority permitted
// requester wins, ties resolved towards the lowest channel index.
module arbitro_por_funcao
  import pkg_funcionalidade::*;
#(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned USER_W  = 3,
  parameter int unsigned FUNC_W  = 3,
  parameter int unsigned FUNC_ID = 1
) (
  input  logic [N_CH*USER_W-1:0] i_user,
  input  logic [N_CH*FUNC_W-1:0] i_func,
  output logic [N_CH-1:0]        o_vencedor,
  output logic                   o_valido,
  output logic [1:0]             o_prio
);

  logic [USER_W-1:0] w_u;
  logic [FUNC_W-1:0] w_f;
  logic [1:0]        w_p;

  always_comb begin
    o_vencedor = '0;
    o_valido   = 1'b0;
    o_prio     = '0;
    w_u        = '0;
    w_f        = '0;
    w_p        = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      w_u = i_user[i*USER_W +: USER_W];
      w_f = i_func[i*FUNC_W +: FUNC_W];
      w_p = prioridade(32'(w_u));
      // Strict '>' keeps the earlier (lower-index) channel on equal priority.
      if (w_f == FUNC_W'(FUNC_ID) && permitido(32'(w_u), 32'(w_f)) &&
          (!o_valido || w_p > o_prio)) begin
        o_vencedor = N_CH'(1) << i;
        o_valido   = 1'b1;
        o_prio     = w_p;
      end
    end
  end

endmodule

// File: rtl/arbitro_de_funcionalidade_seq.sv
// Sequential permission/priority arbiter: registers user requests, grants
// functions for a fixed window, supports preemption and confirmed autopilot.
module arbitro_de_funcionalidade_seq
  import pkg_funcionalidade::*;
#(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned USER_W      = 3,
  parameter int unsigned FUNC_W      = 3,
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter int unsigned AP_CONFIRM  = 16
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [N_CH*USER_W-1:0]   User,
  input  logic [N_CH*FUNC_W-1:0]   Func,
  output logic [(2**FUNC_W)-1:0]   Func_on,
  output logic [N_CH-1:0]          Grant,
  output logic                     Busy,
  output logic                     Piloto,
  output logic [N_CH-1:0]          Denied
);

  localparam int unsigned N_FN  = 2**FUNC_W;
  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES);
  localparam int unsigned AP_W  = $clog2(AP_CONFIRM + 1);

  logic [N_CH*USER_W-1:0] r_user, r_user_d;
  logic [N_CH*FUNC_W-1:0] r_func, r_func_d;
  estado_t                r_estado;
  logic [CNT_W-1:0]       r_cnt;
  logic [AP_W-1:0]        r_ap_cnt;
  logic [N_CH-1:0]        r_grant;
  logic [N_FN-1:0]        r_func_on;
  logic                   r_busy;
  logic                   r_piloto;
  logic [N_CH-1:0]        r_denied;
  logic [N_FN-1:1][1:0]   r_hold_prio;

  logic [N_FN-1:1][N_CH-1:0] w_venc;
  logic [N_CH-1:0][N_FN-1:1] w_venc_t;
  logic [N_FN-1:1]           w_fvalid;
  logic [N_FN-1:1][1:0]      w_fprio;
  logic [N_FN-1:1]           w_preempt_f;
  logic [N_CH-1:0]           w_grant_next;
  logic [N_CH-1:0]           w_user_ones;
  logic [N_CH-1:0]           w_deny;
  logic                      w_any_valid;
  logic                      w_preempt;
  logic                      w_all_ones;
  logic                      w_ap_enter;

  for (genvar f = 1; f < N_FN; f++) begin : g_fn
    arbitro_por_funcao #(
      .N_CH    (N_CH),
      .USER_W  (USER_W),
      .FUNC_W  (FUNC_W),
      .FUNC_ID (f)
    ) u_arb (
      .i_user     (r_user),
      .i_func     (r_func),
      .o_vencedor (w_venc[f]),
      .o_valido   (w_fvalid[f]),
      .o_prio     (w_fprio[f])
    );

    // Only an active function can be preempted, and only by strictly higher priority.
    assign w_preempt_f[f] = r_func_on[f] && w_fvalid[f] && (w_fprio[f] > r_hold_prio[f]);
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [USER_W-1:0] w_u, w_u_d;
    logic [FUNC_W-1:0] w_f, w_f_d;

    assign w_u   = r_user[c*USER_W +: USER_W];
    assign w_u_d = r_user_d[c*USER_W +: USER_W];
    assign w_f   = r_func[c*FUNC_W +: FUNC_W];
    assign w_f_d = r_func_d[c*FUNC_W +: FUNC_W];

    for (genvar f = 1; f < N_FN; f++) begin : g_t
      assign w_venc_t[c][f] = w_venc[f][c];
    end

    assign w_grant_next[c] = |w_venc_t[c];
    assign w_user_ones[c]  = (w_u == '1);
    assign w_deny[c]       = ((w_u != w_u_d) || (w_f != w_f_d)) && (w_f != '0) &&
                             !permitido(32'(w_u), 32'(w_f));
  end

  assign w_any_valid = |w_fvalid;
  assign w_preempt   = |w_preempt_f;
  assign w_all_ones  = &w_user_ones;
  assign w_ap_enter  = (r_estado != PILOTO) && (r_ap_cnt == AP_W'(AP_CONFIRM)) && w_all_ones;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_user      <= '0;
      r_func      <= '0;
      r_user_d    <= '0;
      r_func_d    <= '0;
      r_estado    <= IDLE;
      r_cnt       <= '0;
      r_ap_cnt    <= '0;
      r_grant     <= '0;
      r_func_on   <= '0;
      r_busy      <= 1'b0;
      r_piloto    <= 1'b0;
      r_denied    <= '0;
      r_hold_prio <= '0;
    end else begin
      r_user   <= User;
      r_func   <= Func;
      r_user_d <= r_user;
      r_func_d <= r_func;
      r_denied <= w_deny;

      if (!w_all_ones)
        r_ap_cnt <= '0;
      else if (r_ap_cnt != AP_W'(AP_CONFIRM))
        r_ap_cnt <= r_ap_cnt + 1'b1;

      if (w_ap_enter) begin
        r_estado  <= PILOTO;
        r_piloto  <= 1'b1;
        r_grant   <= '0;
        r_func_on <= '0;
        r_busy    <= 1'b0;
        r_cnt     <= '0;
      end else begin
        unique case (r_estado)
          IDLE: begin
            if (w_any_valid)
              r_estado <= ARBITRATE;
          end
          ARBITRATE: begin
            // Requests may vanish between detection and arbitration; nothing to hold then.
            if (w_any_valid) begin
              r_estado    <= HOLD;
              r_grant     <= w_grant_next;
              r_func_on   <= {w_fvalid, 1'b0};
              r_hold_prio <= w_fprio;
              r_busy      <= 1'b1;
              r_cnt       <= CNT_W'(HOLD_CYCLES - 1);
            end else begin
              r_estado  <= IDLE;
              r_grant   <= '0;
              r_func_on <= '0;
            end
          end
          HOLD: begin
            if (w_preempt) begin
              r_estado <= ARBITRATE;
              r_busy   <= 1'b0;
            end else if (r_cnt == '0) begin
              r_busy <= 1'b0;
              if (w_any_valid) begin
                r_estado <= ARBITRATE;
              end else begin
                r_estado  <= IDLE;
                r_grant   <= '0;
                r_func_on <= '0;
              end
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          PILOTO: begin
            if (!w_all_ones) begin
              r_estado <= IDLE;
              r_piloto <= 1'b0;
            end
          end
          default: r_estado <= IDLE;
        endcase
      end
    end
  end

  assign Func_on = r_func_on;
  assign Grant   = r_grant;
  assign Busy    = r_busy;
  assign Piloto  = r_piloto;
  assign Denied  = r_denied;

endmodule

// File: tb/tb_arbitro_de_funcionalidade_seq.sv
// Bench for arbitro_de_funcionalidade_seq: table-driven reference model,
// per-cycle output comparison, directed scenarios and randomized traffic.
`timescale 1ns/100ps
module tb_arbitro_de_funcionalidade_seq;

  localparam int NC = 2;
  localparam int NF = 8;
  localparam int HC = 8;
  localparam int AC = 4;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b1;
  logic [NC*3-1:0] User = '0;
  logic [NC*3-1:0] Func = '0;
  logic [NF-1:0] Func_on;
  logic [NC-1:0] Grant;
  logic          Busy;
  logic          Piloto;
  logic [NC-1:0] Denied;

  arbitro_de_funcionalidade_seq #(
    .N_CH        (NC),
    .USER_W      (3),
    .FUNC_W      (3),
    .HOLD_CYCLES (HC),
    .AP_CONFIRM  (AC)
  ) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .User    (User),
    .Func    (Func),
    .Func_on (Func_on),
    .Grant   (Grant),
    .Busy    (Busy),
    .Piloto  (Piloto),
    .Denied  (Denied)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Permission table indexed by user code: priority and highest allowed function.
  int prio_tab [8] = '{0, 1, 0, 1, 0, 3, 1, 0};
  int maxf_tab [8] = '{0, 3, 0, 3, 0, 7, 3, 0};

  typedef enum {M_IDLE, M_ARB, M_HOLD, M_AP} mode_t;
  mode_t md = M_IDLE;
  int m_u [NC] = '{default: 0};
  int m_f [NC] = '{default: 0};
  int p_u [NC] = '{default: 0};
  int p_f [NC] = '{default: 0};
  int hp  [NF] = '{default: 0};
  int left = 0;
  int ap = 0;
  logic [NC-1:0] e_grant = '0;
  logic [NC-1:0] e_den = '0;
  logic [NF-1:0] e_fon = '0;
  logic          e_busy = 1'b0;
  logic          e_pil = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    md = M_IDLE; left = 0; ap = 0;
    for (int c = 0; c < NC; c++) begin m_u[c] = 0; m_f[c] = 0; p_u[c] = 0; p_f[c] = 0; end
    for (int f = 0; f < NF; f++) hp[f] = 0;
    e_grant = '0; e_den = '0; e_fon = '0; e_busy = 1'b0; e_pil = 1'b0;
  endtask

  task automatic model_step();
    int win [NF];
    int wpr [NF];
    bit any_v, pre, ones, ap_go;
    logic [NC-1:0] g_n, d_n;
    logic [NF-1:0] f_n;
    any_v = 0; pre = 0; ones = 1; g_n = '0; d_n = '0; f_n = '0;
    for (int f = 0; f < NF; f++) begin win[f] = -1; wpr[f] = 0; end
    for (int f = 1; f < NF; f++) begin
      for (int p = 3; p >= 1; p--)
        for (int c = 0; c < NC; c++)
          if (win[f] < 0 && m_f[c] == f && f <= maxf_tab[m_u[c]] && prio_tab[m_u[c]] == p) begin
            win[f] = c; wpr[f] = p;
          end
      if (win[f] >= 0) begin
        any_v = 1; g_n[win[f]] = 1'b1; f_n[f] = 1'b1;
        if (e_fon[f] && wpr[f] > hp[f]) pre = 1;
      end
    end
    for (int c = 0; c < NC; c++) begin
      if (m_u[c] != 7) ones = 0;
      if ((m_u[c] != p_u[c] || m_f[c] != p_f[c]) && m_f[c] != 0 && m_f[c] > maxf_tab[m_u[c]])
        d_n[c] = 1'b1;
    end
    ap_go = (md != M_AP) && (ap == AC) && ones;

    if (ap_go) begin
      md = M_AP; e_pil = 1'b1; e_grant = '0; e_fon = '0; e_busy = 1'b0;
    end else begin
      case (md)
        M_IDLE: if (any_v) md = M_ARB;
        M_ARB: begin
          if (any_v) begin
            md = M_HOLD; e_grant = g_n; e_fon = f_n; e_busy = 1'b1; left = HC;
            for (int f = 0; f < NF; f++) hp[f] = wpr[f];
          end else begin
            md = M_IDLE; e_grant = '0; e_fon = '0;
          end
        end
        M_HOLD: begin
          if (pre) begin
            md = M_ARB; e_busy = 1'b0;
          end else if (left == 1) begin
            e_busy = 1'b0;
            if (any_v) md = M_ARB;
            else begin md = M_IDLE; e_grant = '0; e_fon = '0; end
          end else begin
            left--;
          end
        end
        default: if (!ones) begin md = M_IDLE; e_pil = 1'b0; end
      endcase
    end

    ap = ones ? ((ap < AC) ? ap + 1 : ap) : 0;
    e_den = d_n;
    for (int c = 0; c < NC; c++) begin
      p_u[c] = m_u[c]; p_f[c] = m_f[c];
      m_u[c] = int'(User[c*3 +: 3]);
      m_f[c] = int'(Func[c*3 +: 3]);
    end
  endtask

  initial forever begin
    @(posedge Clk or negedge Rst_n);
    if (!Rst_n) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge Clk);
    if (Rst_n && chk_en) begin
      check("grant",   32'(Grant),   32'(e_grant));
      check("func_on", 32'(Func_on), 32'(e_fon));
      check("busy",    32'(Busy),    32'(e_busy));
      check("piloto",  32'(Piloto),  32'(e_pil));
      check("denied",  32'(Denied),  32'(e_den));
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic put(input logic [2:0] u0, input logic [2:0] f0, input logic [2:0] u1, input logic [2:0] f1);
    User = {u1, u0};
    Func = {f1, f0};
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  logic [2:0] cu [NC];
  logic [2:0] cf [NC];
  int burst;

  initial begin
    #1 Rst_n = 1'b0;
    tick(2);
    check("rst_grant",   32'(Grant),   32'd0);
    check("rst_func_on", 32'(Func_on), 32'd0);
    check("rst_busy",    32'(Busy),    32'd0);
    check("rst_piloto",  32'(Piloto),  32'd0);
    Rst_n = 1'b1;
    chk_en = 1;
    tick(2);

    // Same function, admin vs user: admin (ch0) wins, 3-cycle latency, 8-cycle window.
    put(3'b101, 3'd1, 3'b001, 3'd1);
    tick(2); check("t1_latency", 32'(Func_on), 32'h00);
    tick(1);
    check("t1_grant", 32'(Grant), 32'h1);
    check("t1_func_on", 32'(Func_on), 32'h02);
    check("t1_busy", 32'(Busy), 32'd1);
    put(0, 0, 0, 0);
    tick(7); check("t1_busy_last", 32'(Busy), 32'd1);
    tick(1);
    check("t1_busy_clear", 32'(Busy), 32'd0);
    check("t1_func_on_clear", 32'(Func_on), 32'h00);
    tick(3);

    // Different functions granted together.
    put(3'b101, 3'd2, 3'b001, 3'd1);
    tick(3);
    check("t2_grant", 32'(Grant), 32'h3);
    check("t2_func_on", 32'(Func_on), 32'h06);
    put(0, 0, 0, 0);
    tick(12);

    // Preemption of a user holder by admin in the 3rd hold cycle; window restarts.
    put(3'b000, 3'd0, 3'b001, 3'd1);
    tick(3); check("t3_grant_user", 32'(Grant), 32'h2);
    tick(2); put(3'b101, 3'd1, 3'b001, 3'd1);
    tick(1); check("t3_still_user", 32'(Grant), 32'h2);
    tick(1); check("t3_arb_busy", 32'(Busy), 32'd0);
    tick(1);
    check("t3_grant_admin", 32'(Grant), 32'h1);
    check("t3_busy", 32'(Busy), 32'd1);
    put(0, 0, 0, 0);
    tick(7); check("t3_reload_busy", 32'(Busy), 32'd1);
    tick(1); check("t3_expire", 32'(Busy), 32'd0);
    tick(3);

    // Equal priority tie goes to the lower index.
    put(3'b110, 3'd2, 3'b011, 3'd2);
    tick(3); check("t4_tie_grant", 32'(Grant), 32'h1);
    put(0, 0, 0, 0);
    tick(12);

    // Non-permitted request: single Denied pulse, no grant.
    put(3'b001, 3'd5, 3'b000, 3'd0);
    tick(1); check("t5_den_early", 32'(Denied), 32'h0);
    tick(1); check("t5_den_pulse", 32'(Denied), 32'h1);
    tick(1); check("t5_den_gone", 32'(Denied), 32'h0);
    tick(3);
    check("t5_den_norepeat", 32'(Denied), 32'h0);
    check("t5_busy", 32'(Busy), 32'd0);
    put(0, 0, 0, 0);
    tick(3);

    // Autopilot confirmation and exit.
    put(3'b111, 3'd0, 3'b111, 3'd0);
    tick(5); check("t6_pil_wait", 32'(Piloto), 32'd0);
    tick(1);
    check("t6_pil_on", 32'(Piloto), 32'd1);
    check("t6_pil_grant", 32'(Grant), 32'h0);
    tick(2); put(3'b111, 3'd0, 3'b001, 3'd0);
    tick(1); check("t6_pil_hold", 32'(Piloto), 32'd1);
    tick(1); check("t6_pil_off", 32'(Piloto), 32'd0);
    put(0, 0, 0, 0);
    tick(3);

    // Asynchronous reset in the middle of a hold window.
    put(3'b101, 3'd3, 3'b000, 3'd0);
    tick(5);
    check("t7_busy", 32'(Busy), 32'd1);
    check("t7_func_on", 32'(Func_on), 32'h08);
    @(posedge Clk);
    #2 Rst_n = 1'b0;
    #0.5;
    check("t7_rst_grant", 32'(Grant), 32'h0);
    check("t7_rst_func_on", 32'(Func_on), 32'h00);
    check("t7_rst_busy", 32'(Busy), 32'd0);
    check("t7_rst_piloto", 32'(Piloto), 32'd0);
    #0.5 Rst_n = 1'b1;
    put(0, 0, 0, 0);
    tick(4);

    // Randomized traffic with occasional all-autopilot bursts.
    for (int c = 0; c < NC; c++) begin cu[c] = '0; cf[c] = '0; end
    burst = 0;
    for (int k = 0; k < 1500; k++) begin
      @(negedge Clk);
      if (burst > 0) begin
        burst--;
        for (int c = 0; c < NC; c++) begin
          cu[c] = 3'b111;
          if ($urandom_range(0, 3) == 0) cf[c] = 3'($urandom_range(0, 7));
        end
      end else if ($urandom_range(0, 99) < 2) begin
        burst = $urandom_range(2, 9);
      end else begin
        for (int c = 0; c < NC; c++) begin
          if ($urandom_range(0, 3) == 0) begin
            cu[c] = ($urandom_range(0, 9) >= 8) ? 3'b101 : 3'($urandom_range(0, 7));
            cf[c] = ($urandom_range(0, 9) < 4) ? 3'd0 : 3'($urandom_range(1, 7));
          end
        end
      end
      put(cu[0], cf[0], cu[1], cf[1]);
    end
    put(0, 0, 0, 0);
    tick(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
